// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP frame emitter: FSM state codes, pattern
// selector encodings and the colour-bar palette.
package dvp_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFRONT = 3'd4;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 pixel source: colour bars, ramp, solid colour or
// checkerboard, selected by the per-frame latched pattern code.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  pattern_e    sel,
  input  logic [15:0] solid_rgb,
  output logic [15:0] rgb
);

  logic [2:0] bar;
  logic       chk;

  always_comb begin
    bar = 3'((32'(x) * 32'd8) / 32'(H_ACTIVE));
    // 16-pixel squares: only bit 4 of x^y matters
    chk = |((x ^ y) & 16'h0010);
    case (sel)
      PAT_BARS:  rgb = bar_colour(bar);
      PAT_RAMP:  rgb = {x[8:4], x[8:3], x[8:4]};
      PAT_SOLID: rgb = solid_rgb;
      PAT_CHECK: rgb = chk ? 16'hFFFF : 16'h0000;
      default:   rgb = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_frame_emitter.sv
// OV7670-style DVP transmitter: VSYNC/HREF framing with an RGB565 byte
// stream (high byte first), one byte per slot of CLK_DIV clocks.
//
// state     | meaning
// IDLE      | no framing, outputs quiet, waiting for enable
// VSYNC     | VS_LINES line periods with dvp_vsync high
// VBACK     | V_BACK blank line periods before the first active line
// ACTIVE    | V_ACTIVE lines: 2*H_ACTIVE bytes with HREF, then H_BLANK idle
// VFRONT    | V_FRONT blank line periods, frame counted at the end
module dvp_frame_emitter
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        dvp_pclk_en,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int SLOT_W     = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int MAX_AB     = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int MAX_CD     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int LINE_MAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LINE_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [15:0]         fcount_q, fcount_d;
  pattern_e            sel_q, sel_d;
  logic [15:0]         solid_q, solid_d;

  logic                slot_end, line_end, region_end, start_frame;
  logic [LINE_W-1:0]   region_last;
  logic [15:0]         pix_rgb;

  always_comb begin
    case (state_q)
      ST_VSYNC:  region_last = LINE_W'(VS_LINES - 1);
      ST_VBACK:  region_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE: region_last = LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: region_last = LINE_W'(V_FRONT - 1);
      default:   region_last = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    slot_d      = slot_q;
    line_d      = line_q;
    fcount_d    = fcount_q;
    sel_d       = sel_q;
    solid_d     = solid_q;
    start_frame = 1'b0;

    slot_end   = (state_q != ST_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    line_end   = slot_end && (slot_q == SLOT_W'(LINE_SLOTS - 1));
    region_end = line_end && (line_q == region_last);

    if (state_q == ST_IDLE) begin
      start_frame = enable;
    end else begin
      div_d = slot_end ? '0 : div_q + DIV_W'(1);
      if (slot_end) slot_d = line_end ? '0 : slot_q + SLOT_W'(1);
      if (line_end) line_d = region_end ? '0 : line_q + LINE_W'(1);
      if (region_end) begin
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: begin
            fcount_d = fcount_q + 16'd1;
            if (enable) start_frame = 1'b1;
            else        state_d     = ST_IDLE;
          end
          default:   state_d = ST_IDLE;
        endcase
      end
    end

    // Pattern controls are frozen for the whole frame at VSYNC entry
    if (start_frame) begin
      state_d = ST_VSYNC;
      div_d   = '0;
      slot_d  = '0;
      line_d  = '0;
      sel_d   = pattern_e'(pattern_sel);
      solid_d = solid_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      slot_q   <= '0;
      line_q   <= '0;
      fcount_q <= '0;
      sel_q    <= PAT_BARS;
      solid_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      slot_q   <= slot_d;
      line_q   <= line_d;
      fcount_q <= fcount_d;
      sel_q    <= sel_d;
      solid_q  <= solid_d;
    end
  end

  dvp_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .x         (16'(slot_q >> 1)),
    .y         (16'(line_q)),
    .sel       (sel_q),
    .solid_rgb (solid_q),
    .rgb       (pix_rgb)
  );

  // Outputs decode registered position only, so they move solely on slot starts
  always_comb begin
    busy        = (state_q != ST_IDLE);
    dvp_vsync   = (state_q == ST_VSYNC);
    dvp_pclk_en = busy && (div_q == '0);
    dvp_href    = (state_q == ST_ACTIVE) && (32'(slot_q) < 32'(2 * H_ACTIVE));
    dvp_data    = 8'h00;
    if (dvp_href) dvp_data = slot_q[0] ? pix_rgb[7:0] : pix_rgb[15:8];
    frame_count = fcount_q;
  end

endmodule

// File: tb/tb_dvp_frame_emitter.sv
// Bench for dvp_frame_emitter: two instances (byte-rate and divided clock)
// checked every cycle against a time-in-frame reference model.
module tb_dvp_frame_emitter;

  localparam int H1 = 8,  V1 = 4,  HB1 = 4, VS1 = 1, VB1 = 1, VF1 = 1, CD1 = 1;
  localparam int H2 = 40, V2 = 20, HB2 = 6, VS2 = 2, VB2 = 2, VF2 = 1, CD2 = 3;

  int P_H[2]  = '{H1, H2};
  int P_V[2]  = '{V1, V2};
  int P_HB[2] = '{HB1, HB2};
  int P_VS[2] = '{VS1, VS2};
  int P_VB[2] = '{VB1, VB2};
  int P_VF[2] = '{VF1, VF2};
  int P_CD[2] = '{CD1, CD2};

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  bar_line [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;

  logic        d1_vsync, d1_href, d1_pclk, d1_busy;
  logic [7:0]  d1_data;
  logic [15:0] d1_fc;
  logic        d2_vsync, d2_href, d2_pclk, d2_busy;
  logic [7:0]  d2_data;
  logic [15:0] d2_fc;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dvp_frame_emitter #(.H_ACTIVE(H1), .V_ACTIVE(V1), .H_BLANK(HB1), .VS_LINES(VS1),
                      .V_BACK(VB1), .V_FRONT(VF1), .CLK_DIV(CD1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .dvp_vsync(d1_vsync), .dvp_href(d1_href), .dvp_data(d1_data), .dvp_pclk_en(d1_pclk),
    .frame_count(d1_fc), .busy(d1_busy));

  dvp_frame_emitter #(.H_ACTIVE(H2), .V_ACTIVE(V2), .H_BLANK(HB2), .VS_LINES(VS2),
                      .V_BACK(VB2), .V_FRONT(VF2), .CLK_DIV(CD2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .dvp_vsync(d2_vsync), .dvp_href(d2_href), .dvp_data(d2_data), .dvp_pclk_en(d2_pclk),
    .frame_count(d2_fc), .busy(d2_busy));

  // ---------------- reference model: clocks elapsed since VSYNC entry ----------------
  bit          m_busy [2];
  int          m_t    [2];
  logic [15:0] m_fc   [2];
  int          m_sel  [2];
  logic [15:0] m_solid[2];

  function automatic int frame_clks(int i);
    return (2 * P_H[i] + P_HB[i]) * (P_VS[i] + P_VB[i] + P_V[i] + P_VF[i]) * P_CD[i];
  endfunction

  function automatic logic [15:0] pix(int i, int sel, logic [15:0] solid, int x, int y);
    case (sel)
      0: return bars[(x * 8) / P_H[i]];
      1: return 16'((((x >> 4) & 31) << 11) | (((x >> 3) & 63) << 5) | ((x >> 4) & 31));
      2: return solid;
      default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // {vsync, href, pclk_en, busy, data, frame_count}
  function automatic logic [27:0] expect_out(int i);
    int s, ls, ln, c, a;
    logic vs, hr, pc;
    logic [7:0] d;
    logic [15:0] p;
    if (!m_busy[i]) return {4'b0000, 8'h00, m_fc[i]};
    s  = m_t[i] / P_CD[i];
    pc = (m_t[i] % P_CD[i]) == 0;
    ls = 2 * P_H[i] + P_HB[i];
    ln = s / ls;
    c  = s % ls;
    a  = ln - P_VS[i] - P_VB[i];
    vs = ln < P_VS[i];
    hr = (a >= 0) && (a < P_V[i]) && (c < 2 * P_H[i]);
    d  = 8'h00;
    if (hr) begin
      p = pix(i, m_sel[i], m_solid[i], c / 2, a);
      d = (c % 2 == 0) ? p[15:8] : p[7:0];
    end
    return {vs, hr, pc, 1'b1, d, m_fc[i]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_t[i] = 0; m_fc[i] = 16'd0;
      end else if (!m_busy[i]) begin
        if (enable) begin
          m_busy[i] = 1'b1; m_t[i] = 0; m_sel[i] = int'(pattern_sel); m_solid[i] = solid_rgb;
        end
      end else begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == frame_clks(i)) begin
          m_fc[i] = m_fc[i] + 16'd1;
          if (enable) begin
            m_t[i] = 0; m_sel[i] = int'(pattern_sel); m_solid[i] = solid_rgb;
          end else begin
            m_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [27:0] act, exp_v;
  logic        p2_busy = 1'b0, p2_href = 1'b0;
  logic [7:0]  p2_data = 8'h00;
  int          gap2 = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        act   = (i == 0) ? {d1_vsync, d1_href, d1_pclk, d1_busy, d1_data, d1_fc}
                         : {d2_vsync, d2_href, d2_pclk, d2_busy, d2_data, d2_fc};
        exp_v = expect_out(i);
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL cycle_dut%0d t=%0t {vs,href,pclk,busy,data,fc} got=%h expected=%h",
                   i + 1, $time, act, exp_v);
        end
      end
      // divided-clock instance: strobe spacing and hold between strobes
      if (d2_busy && p2_busy) begin
        if (!d2_pclk) begin
          checks++;
          if (d2_href !== p2_href || d2_data !== p2_data) begin
            errors++;
            $display("FAIL hold_between_strobes t=%0t got href=%b data=%h expected href=%b data=%h",
                     $time, d2_href, d2_data, p2_href, p2_data);
          end
        end else if (gap2 >= 0) begin
          checks++;
          if (gap2 != 3) begin
            errors++;
            $display("FAIL pclk_period t=%0t got=%0d expected=3", $time, gap2);
          end
        end
      end
      if (!d2_busy) gap2 = -1;
      else if (d2_pclk) gap2 = 1;
      else if (gap2 >= 0) gap2++;
      p2_busy = d2_busy; p2_href = d2_href; p2_data = d2_data;
    end
  end

  task automatic check_val(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int vs_cnt, href_rises, bidx, found;
    logic prev_href;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_val("reset_outputs", {d1_vsync, d1_href, d1_pclk, d1_busy, d1_data}, 0);
    check_val("reset_frame_count", d1_fc, 0);

    // solid A55A, switched to checker mid-frame
    pattern_sel = 2'd2; solid_rgb = 16'hA55A; enable = 1'b1;
    @(negedge clk);
    vs_cnt = 0; href_rises = 0; bidx = 0; prev_href = 1'b0;
    for (int k = 0; k < 140; k++) begin
      if (d1_vsync) vs_cnt++;
      if (d1_href && !prev_href) href_rises++;
      prev_href = d1_href;
      if (d1_href) begin
        check_val("solid_byte", d1_data, (bidx % 2 == 0) ? 8'hA5 : 8'h5A);
        bidx++;
      end
      if (k == 60) pattern_sel = 2'd3;
      if (k == 139) check_val("frame_count_before_end", d1_fc, 0);
      @(negedge clk);
    end
    check_val("vsync_high_clks", vs_cnt, 20);
    check_val("href_pulses", href_rises, 4);
    check_val("href_bytes", bidx, 64);
    check_val("frame_count_at_140", d1_fc, 1);
    check_val("second_vsync", d1_vsync, 1);

    // colour bars on the first active line
    pulse_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (d1_href) found = 1;
    end
    check_val("bars_href_seen", found, 1);
    if (found == 1) begin
      for (int b = 0; b < 16; b++) begin
        check_val("bars_byte", d1_data, int'(bar_line[b]));
        @(negedge clk);
      end
    end

    // enable dropped during active line 2: frame completes, then idle
    pulse_reset();
    pattern_sel = 2'd2; solid_rgb = 16'h1234; enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 140; k++) begin
      if (k == 83) enable = 1'b0;
      @(negedge clk);
    end
    check_val("drop_en_frame_count", d1_fc, 1);
    check_val("drop_en_busy", d1_busy, 0);
    vs_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (d1_vsync || d1_busy) vs_cnt++;
      @(negedge clk);
    end
    check_val("drop_en_stays_idle", vs_cnt, 0);

    // reset during ACTIVE, then clean restart
    pulse_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    @(negedge clk);
    repeat (50) @(negedge clk);
    check_val("pre_reset_busy", d1_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("midframe_reset_outputs", {d1_vsync, d1_href, d1_pclk, d1_busy, d1_data}, 0);
    check_val("midframe_reset_fc", d1_fc, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("restart_vsync", {d1_vsync, d1_pclk, d1_busy}, 3'b111);

    // randomized run
    for (int k = 0; k < 30000; k++) begin
      if ($urandom_range(1499, 0) == 0) enable = ($urandom_range(3, 0) != 0);
      if ($urandom_range(499, 0) == 0) begin
        pattern_sel = 2'($urandom_range(3, 0));
        solid_rgb   = 16'($urandom);
      end
      if ($urandom_range(7999, 0) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvp_frame_emitter.md
Name: dvp_frame_emitter

Overview:
- Transmit side of the OV7670 DVP pixel interface: generates VSYNC/HREF framing and an RGB565 byte stream, high byte first, two bytes per pixel.
- Drives the camera capture path in place of the sensor, for board bring-up and for SDRAM/VGA loopback without the CMOS device.
- Pixel content comes from an internal pattern generator or from a host-supplied solid colour.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK, 144: idle byte slots between lines (HREF low).
- VS_LINES, 3: line periods with VSYNC high.
- V_BACK, 17: line periods after VSYNC before the first active line.
- V_FRONT, 10: line periods after the last active line before the next VSYNC.
- CLK_DIV, 2: clk cycles per byte slot (≥1).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous reset, active-high.
- enable, in, 1: permit frame generation.
- pattern_sel, in, 2: 0 colour bars, 1 horizontal ramp, 2 solid, 3 checker.
- solid_rgb, in, 16: RGB565 value used when pattern_sel=2.
- dvp_vsync, out, 1: frame sync, active-high.
- dvp_href, out, 1: line valid.
- dvp_data, out, 8: byte bus.
- dvp_pclk_en, out, 1: one-clk strobe marking each byte slot (sampling instant).
- frame_count, out, 16: completed frames, wraps at 0xFFFF→0.
- busy, out, 1: high while a frame is in progress.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- Line period is 2*H_ACTIVE + H_BLANK byte slots. Each slot lasts CLK_DIV clks.
- dvp_pclk_en pulses high for exactly one clk at the start of each slot, in every state except IDLE. Outputs change only on that clk.
- FSM states and transitions:
  - IDLE → VSYNC: taken on the clk after enable is sampled high.
  - VSYNC → VBACK: after VS_LINES line periods. dvp_vsync=1 for exactly VS_LINES*line-period slots.
  - VBACK → ACTIVE: after V_BACK line periods.
  - ACTIVE: per line, HREF=1 for 2*H_ACTIVE slots, then HREF=0 for H_BLANK slots. After V_ACTIVE lines → VFRONT.
  - VFRONT → VSYNC if enable=1, else → IDLE. Either way, frame_count increments on the last slot of VFRONT.
- Bytes within a line:
  - Slot 2x carries pixel x bits[15:8]; slot 2x+1 carries bits[7:0].
  - dvp_data=0 whenever HREF=0.
- Patterns (x = pixel index, y = line index):
  - Colour bars: 8 bars, bar = x*8/H_ACTIVE. Colours in order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - Ramp: R=x[8:4], G=x[8:3], B=x[8:4] (truncated, widths preserved).
  - Solid: solid_rgb.
  - Checker: FFFF if x[4]^y[4], else 0000.
- pattern_sel and solid_rgb are sampled once, at VSYNC entry, and held for the whole frame. A mid-frame change takes effect on the next frame.
- Deasserting enable mid-frame does not truncate the frame. The current frame completes, then the FSM goes to IDLE.
- busy=1 in every state except IDLE.
- Reset asserted mid-frame: all outputs return to 0 on the next clk and the frame is abandoned without incrementing frame_count.
- Counters: slot counter is log2(2*H_ACTIVE+H_BLANK) bits; line counter covers the largest of VS_LINES, V_BACK, V_ACTIVE, V_FRONT. No overflow at the parameter bounds.

Decomposition:
- Shared package dvp_pkg holds:
  - FSM state enum: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - The pattern_sel encodings.
  - The 8 colour-bar RGB565 constants.
- Sub-module dvp_pattern_gen: combinational/registered pixel from (x, y, latched sel, latched solid).
- Timing FSM and counters stay in the top module.

Test Plan:
- Small params (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1, CLK_DIV=1), enable=1, solid_rgb=0xA55A, sel=2:
  - Every HREF line is 16 bytes alternating A5,5A.
  - 4 HREF pulses per frame.
  - VSYNC high 20 clks.
  - frame_count=1 after 140 clks from VSYNC entry.
- Same params, sel=0, H_ACTIVE=8: pixel bytes per line are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- CLK_DIV=3: dvp_pclk_en period is exactly 3 clks; dvp_data and dvp_href are stable between strobes.
- Drop enable during line 2 of frame 0: frame completes all 4 lines, busy falls after VFRONT, frame_count=1, no second VSYNC.
- Switch sel from 2 to 3 mid-frame: rest of the frame stays solid; the next frame is checker.
- Assert rst mid-ACTIVE: next clk all outputs are 0, frame_count is unchanged (0); re-enable restarts cleanly with VSYNC.
